// File: rtl/key_remap_ctrl_if.sv
// Key-remap front-end bundle: key/mode inputs toward the controller,
// RAM address/data/strobe and status back out.
interface key_remap_ctrl_if #(
  parameter int KEY_BITS = 7
);
  logic [KEY_BITS-1:0] key_in;
  logic                learn_en;
  logic [KEY_BITS-1:0] ram_addr;
  logic [KEY_BITS-1:0] ram_in;
  logic                ram_rw;
  logic [1:0]          learn_state;
  logic                done;
  logic                err;

  modport master (
    input  key_in,
    input  learn_en,
    output ram_addr,
    output ram_in,
    output ram_rw,
    output learn_state,
    output done,
    output err
  );

  modport slave (
    output key_in,
    output learn_en,
    input  ram_addr,
    input  ram_in,
    input  ram_rw,
    input  learn_state,
    input  done,
    input  err
  );
endinterface

// File: rtl/key_remap_ctrl.sv
// Key-remap RAM front end: forwards one-hot keys in play mode and
// captures a source->target pair in learn mode, then pulses one write.
module key_remap_ctrl #(
  parameter int KEY_BITS       = 7,
  parameter int TIMEOUT_CYCLES = 500_000_000
) (
  input logic              clk,
  input logic              rst_n,
  key_remap_ctrl_if.master bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  typedef logic [KEY_BITS-1:0] key_t;

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    SRC  = 2'd1,
    DST  = 2'd2,
    WR   = 2'd3
  } state_t;

  state_t        state;
  key_t          s1;
  key_t          s2;
  key_t          prev;
  key_t          src_q;
  key_t          dst_q;
  key_t          addr_q;
  logic [TW-1:0] timer;
  logic          rw_q;
  logic          done_q;
  logic          err_q;

  logic onehot;
  logic press;
  logic hit_to;

  assign onehot = (s2 != '0)
               && ((s2 & (s2 - key_t'(1))) == '0);
  assign press  = (prev == '0) && (s2 != '0);
  assign hit_to = (timer == TLAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= bus.key_in;
      s2   <= s1;
      prev <= s2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= PLAY;
      src_q  <= '0;
      dst_q  <= '0;
      addr_q <= '0;
      timer  <= '0;
      rw_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      rw_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      addr_q <= '0;
      dst_q  <= '0;
      unique case (state)
        PLAY: begin
          timer <= '0;
          if (bus.learn_en)
            state <= SRC;
          else if (onehot)
            addr_q <= s2;
        end
        SRC, DST: begin
          // abort beats timeout, timeout beats a press
          if (!bus.learn_en) begin
            state <= PLAY;
            timer <= '0;
          end else if (hit_to) begin
            state <= PLAY;
            err_q <= 1'b1;
            timer <= '0;
          end else if (press) begin
            timer <= '0;
            if (!onehot) begin
              err_q <= 1'b1;
            end else if (state == SRC) begin
              src_q <= s2;
              state <= DST;
            end else begin
              state  <= WR;
              dst_q  <= s2;
              addr_q <= src_q;
              rw_q   <= 1'b1;
              done_q <= 1'b1;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        WR: begin
          timer <= '0;
          state <= bus.learn_en ? SRC : PLAY;
        end
        default: state <= PLAY;
      endcase
    end
  end

  assign bus.ram_addr    = addr_q;
  assign bus.ram_in      = dst_q;
  assign bus.ram_rw      = rw_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.learn_state = state;
endmodule

// File: tb/tb_key_remap_ctrl.sv
// Bench for key_remap_ctrl: play-forwarding vector table, directed
// learn sequences, then random keys against a queue-based model.
module tb_key_remap_ctrl;
  localparam int KB = 7;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   rw_cnt = 0;
  bit   mchk = 1'b0;

  key_remap_ctrl_if #(.KEY_BITS(KB)) bus ();

  key_remap_ctrl #(
    .KEY_BITS(KB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [KB-1:0] ram [logic [KB-1:0]];

  always @(negedge clk)
    if (bus.ram_rw) begin
      rw_cnt++;
      ram[bus.ram_addr] = bus.ram_in;
    end

  // Reference model: h[0] newest sampled key, h[1] is the synchronised key,
  // h[2] the one before it; mode is 0 play, 1 src, 2 dst, 3 write.
  logic [KB-1:0] h[$];
  int            mode;
  int            idle;
  logic [KB-1:0] msrc;
  logic [KB-1:0] e_addr, e_in;
  logic          e_rw, e_done, e_err;

  task automatic mreset();
    h = {7'd0, 7'd0, 7'd0};
    mode = 0; idle = 0; msrc = '0;
    e_addr = '0; e_in = '0;
    e_rw = 0; e_done = 0; e_err = 0;
  endtask

  task automatic mstep(input logic [KB-1:0] k, input logic le);
    logic [KB-1:0] cur, old;
    bit pr, oh;
    cur = h[1];
    old = h[2];
    pr = (old == 0) && (cur != 0);
    oh = ($countones(cur) == 1);
    e_addr = '0; e_in = '0;
    e_rw = 0; e_done = 0; e_err = 0;
    if (mode == 0) begin
      idle = 0;
      if (le) mode = 1;
      else if (oh) e_addr = cur;
    end else if (mode == 3) begin
      idle = 0;
      mode = le ? 1 : 0;
    end else if (!le) begin
      mode = 0; idle = 0;
    end else if (idle == TO - 1) begin
      mode = 0; idle = 0; e_err = 1;
    end else if (pr && !oh) begin
      idle = 0; e_err = 1;
    end else if (pr) begin
      idle = 0;
      if (mode == 1) begin
        msrc = cur; mode = 2;
      end else begin
        mode = 3; e_rw = 1; e_done = 1;
        e_addr = msrc; e_in = cur;
      end
    end else begin
      idle++;
    end
    h.push_front(k);
    void'(h.pop_back());
  endtask

  always @(posedge clk or negedge rst_n)
    if (!rst_n) mreset();
    else mstep(bus.key_in, bus.learn_en);

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [KB-1:0] key;
    logic [KB-1:0] addr;
  } vec_t;

  vec_t tv[6];

  always @(negedge clk)
    if (mchk)
      chk("model", {bus.ram_addr, bus.ram_in, bus.ram_rw, bus.done,
                    bus.err, bus.learn_state},
          {e_addr, e_in, e_rw, e_done, e_err, 2'(mode)});

  initial begin
    logic [KB-1:0] pe;
    int rwc;
    tv[0] = '{7'b0000100, 7'b0000100};
    tv[1] = '{7'b0000110, 7'b0000000};
    tv[2] = '{7'b1000000, 7'b1000000};
    tv[3] = '{7'b0000000, 7'b0000000};
    tv[4] = '{7'b0000001, 7'b0000001};
    tv[5] = '{7'b1111111, 7'b0000000};
    for (int i = 0; i < KB; i++) ram[7'(1 << i)] = 7'(1 << i);
    mreset();
    bus.key_in = '0;
    bus.learn_en = 1'b0;
    tick(2);
    chk("rst_addr", bus.ram_addr, 0);
    chk("rst_rw", bus.ram_rw, 0);
    chk("rst_flags", {bus.done, bus.err, bus.ram_in}, 0);
    chk("rst_state", bus.learn_state, 0);
    rst_n = 1'b1;

    pe = '0;
    for (int i = 0; i < 6; i++) begin
      bus.key_in = tv[i].key;
      tick(2);
      chk("play_lat", bus.ram_addr, pe);
      tick(1);
      chk("play_addr", bus.ram_addr, tv[i].addr);
      chk("play_rw", bus.ram_rw, 0);
      pe = tv[i].addr;
    end

    bus.key_in = '0;
    tick(3);
    bus.learn_en = 1'b1;
    tick(1);
    chk("learn_src", bus.learn_state, 1);
    chk("learn_addr0", bus.ram_addr, 0);
    bus.key_in = 7'b0000010;
    tick(3);
    chk("src_cap", bus.learn_state, 2);
    bus.key_in = '0;
    tick(3);
    bus.key_in = 7'b1000000;
    tick(2);
    chk("dst_wait", {bus.learn_state, bus.ram_rw}, {2'd2, 1'b0});
    tick(1);
    chk("wr_state", bus.learn_state, 3);
    chk("wr_rw", {bus.ram_rw, bus.done}, 2'b11);
    chk("wr_addr", bus.ram_addr, 7'b0000010);
    chk("wr_in", bus.ram_in, 7'b1000000);
    tick(1);
    chk("post_wr", bus.learn_state, 1);
    chk("post_wr_out",
        {bus.ram_rw, bus.done, bus.ram_addr, bus.ram_in}, 0);
    chk("ram_map", ram[7'b0000010], 7'b1000000);

    bus.key_in = '0;
    tick(3);
    bus.key_in = 7'b0000011;
    tick(3);
    chk("multi_err", {bus.err, bus.learn_state}, {1'b1, 2'd1});
    tick(1);
    chk("multi_err_off", bus.err, 0);
    bus.key_in = '0;
    tick(3);
    bus.learn_en = 1'b0;
    tick(1);
    chk("abort_src", bus.learn_state, 0);
    bus.key_in = 7'b0000001;
    tick(3);
    bus.learn_en = 1'b1;
    tick(6);
    chk("hold_nopress", bus.learn_state, 1);
    bus.key_in = '0;
    tick(3);
    bus.key_in = 7'b0000100;
    tick(3);
    chk("press_after", bus.learn_state, 2);

    rwc = rw_cnt;
    bus.key_in = '0;
    tick(15);
    chk("to_wait", {bus.learn_state, bus.err}, {2'd2, 1'b0});
    tick(1);
    chk("to_err", {bus.learn_state, bus.err}, {2'd0, 1'b1});
    tick(1);
    chk("to_err_off", {bus.learn_state, bus.err}, {2'd1, 1'b0});
    chk("to_norw", rw_cnt, rwc);

    bus.key_in = 7'b0000001;
    tick(3);
    chk("dst5", bus.learn_state, 2);
    bus.key_in = '0;
    bus.learn_en = 1'b0;
    tick(1);
    chk("drop_dst", {bus.learn_state, bus.err}, {2'd0, 1'b0});
    chk("drop_norw", rw_cnt, rwc);
    bus.learn_en = 1'b1;
    tick(3);
    bus.key_in = 7'b0000001;
    tick(3);
    chk("dst5b", bus.learn_state, 2);
    bus.key_in = '0;
    tick(3);
    bus.key_in = 7'b0100000;
    tick(3);
    chk("wr5", {bus.learn_state, bus.ram_rw}, {2'd3, 1'b1});
    bus.learn_en = 1'b0;
    tick(1);
    chk("wr5_play", {bus.learn_state, bus.ram_rw}, {2'd0, 1'b0});
    chk("ram_map5", ram[7'b0000001], 7'b0100000);

    bus.key_in = '0;
    bus.learn_en = 1'b1;
    tick(3);
    bus.key_in = 7'b0001000;
    tick(3);
    bus.key_in = '0;
    tick(3);
    bus.key_in = 7'b0000010;
    tick(3);
    chk("wr6", {bus.learn_state, bus.ram_rw}, {2'd3, 1'b1});
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst",
        {bus.ram_rw, bus.done, bus.learn_state}, 0);
    @(negedge clk);
    bus.key_in = 7'b0000100;
    bus.learn_en = 1'b0;
    rst_n = 1'b1;
    tick(3);
    chk("rst_play", {bus.learn_state, bus.ram_addr},
        {2'd0, 7'b0000100});

    mchk = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      #1;
      if ($urandom_range(3) == 0) begin
        int r;
        r = $urandom_range(9);
        if (r < 5) bus.key_in = '0;
        else if (r < 9) bus.key_in = 7'(1 << $urandom_range(KB - 1));
        else bus.key_in = 7'($urandom);
      end
      if ($urandom_range(39) == 0) bus.learn_en = ~bus.learn_en;
    end
    mchk = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
